// File: rtl/fft_pkg.sv
// Shared types for the radix-2 FFT butterfly lane: controller state encoding
// and a default-width complex word.
package fft_pkg;

    localparam int FFT_N_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } fft_state_t;

    typedef struct packed {
        logic [FFT_N_DEFAULT-1:0] re;
        logic [FFT_N_DEFAULT-1:0] im;
    } cplx_t;

endpackage

// File: rtl/butterfly_addsub.sv
// Registered butterfly datapath: c0 = a + p, c1 = a - p per real/imag lane,
// with an optional arithmetic >>1 applied to the (n+1)-bit intermediate.
module butterfly_addsub #(
    parameter int n     = 32,
    parameter bit scale = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [n-1:0] ar,
    input  logic [n-1:0] ac,
    input  logic [n-1:0] pr,
    input  logic [n-1:0] pc,
    output logic [n-1:0] c0r,
    output logic [n-1:0] c0c,
    output logic [n-1:0] c1r,
    output logic [n-1:0] c1c
);

    logic [2*n-1:0] a_all;
    logic [2*n-1:0] p_all;
    logic [2*n-1:0] c0_all;
    logic [2*n-1:0] c1_all;

    assign a_all = {ac, ar};
    assign p_all = {pc, pr};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [n-1:0] a_lane;
            logic [n-1:0] p_lane;
            logic [n:0]   sum_ext;
            logic [n:0]   dif_ext;
            logic [n-1:0] sum_sel;
            logic [n-1:0] dif_sel;
            logic [n-1:0] c0_reg;
            logic [n-1:0] c1_reg;

            assign a_lane = a_all[gi*n +: n];
            assign p_lane = p_all[gi*n +: n];

            // Sign-extended by one bit so the scaled result never wraps.
            always_comb begin
                sum_ext = {a_lane[n-1], a_lane} + {p_lane[n-1], p_lane};
                dif_ext = {a_lane[n-1], a_lane} - {p_lane[n-1], p_lane};
                sum_sel = scale ? sum_ext[n:1] : sum_ext[n-1:0];
                dif_sel = scale ? dif_ext[n:1] : dif_ext[n-1:0];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    c0_reg <= '0;
                    c1_reg <= '0;
                end else if (en) begin
                    c0_reg <= sum_sel;
                    c1_reg <= dif_sel;
                end
            end

            assign c0_all[gi*n +: n] = c0_reg;
            assign c1_all[gi*n +: n] = c1_reg;
        end
    endgenerate

    assign c0r = c0_all[n-1:0];
    assign c0c = c0_all[2*n-1:n];
    assign c1r = c1_all[n-1:0];
    assign c1c = c1_all[2*n-1:n];

endmodule

// File: rtl/fft_butterfly_stage.sv
// Radix-2 DIT butterfly controller: sends b*w to an external complex multiplier,
// holds a meanwhile, and returns a+bw / a-bw over a val/rdy interface.
module fft_butterfly_stage
    import fft_pkg::*;
#(
    parameter int n     = 32,
    parameter int d     = 16,
    parameter bit scale = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] ar,
    input  logic [n-1:0] ac,
    input  logic [n-1:0] br,
    input  logic [n-1:0] bc,
    input  logic [n-1:0] wr,
    input  logic [n-1:0] wc,
    output logic         mult_recv_val,
    input  logic         mult_recv_rdy,
    output logic [n-1:0] mult_ar,
    output logic [n-1:0] mult_ac,
    output logic [n-1:0] mult_br,
    output logic [n-1:0] mult_bc,
    input  logic         mult_send_val,
    output logic         mult_send_rdy,
    input  logic [n-1:0] mult_cr,
    input  logic [n-1:0] mult_cc,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] c0r,
    output logic [n-1:0] c0c,
    output logic [n-1:0] c1r,
    output logic [n-1:0] c1c
);

    generate
        if (d >= n) begin : g_bad_frac
            $error("fft_butterfly_stage: fractional bits d must be below word width n");
        end
    endgenerate

    typedef struct packed {
        logic [n-1:0] re;
        logic [n-1:0] im;
    } word_t;

    fft_state_t state_reg, state_next;
    word_t      a_reg, b_reg, w_reg;
    logic       wait_first_reg;
    logic       capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            w_reg          <= '0;
            wait_first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            // High only in the first WAIT cycle, masking a stale product valid.
            wait_first_reg <= (state_reg == ISSUE);
            if (state_reg == IDLE && recv_val) begin
                a_reg.re <= ar;
                a_reg.im <= ac;
                b_reg.re <= br;
                b_reg.im <= bc;
                w_reg.re <= wr;
                w_reg.im <= wc;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        capture       = 1'b0;
        recv_rdy      = 1'b0;
        mult_recv_val = 1'b0;
        mult_send_rdy = 1'b0;
        send_val      = 1'b0;
        case (state_reg)
            IDLE: begin
                recv_rdy = 1'b1;
                if (recv_val) state_next = ISSUE;
            end
            ISSUE: begin
                mult_recv_val = 1'b1;
                if (mult_recv_rdy) state_next = WAIT;
            end
            WAIT: begin
                mult_send_rdy = 1'b1;
                if (mult_send_val && !wait_first_reg) begin
                    capture    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                send_val = 1'b1;
                if (send_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mult_ar = b_reg.re;
    assign mult_ac = b_reg.im;
    assign mult_br = w_reg.re;
    assign mult_bc = w_reg.im;

    butterfly_addsub #(
        .n     (n),
        .scale (scale)
    ) u_addsub (
        .clk   (clk),
        .reset (reset),
        .en    (capture),
        .ar    (a_reg.re),
        .ac    (a_reg.im),
        .pr    (mult_cr),
        .pc    (mult_cc),
        .c0r   (c0r),
        .c0c   (c0c),
        .c1r   (c1r),
        .c1c   (c1c)
    );

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Directed bench for fft_butterfly_stage: unscaled and scaled instances run in
// lockstep against a behavioural fixed-point multiplier with settable latency.
module tb_fft_butterfly_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        recv_val;
    logic        recv_rdy, recv_rdy_s;
    logic [31:0] ar, ac, br, bc, wr, wc;
    logic        mult_recv_val, mult_recv_val_s;
    logic        mult_recv_rdy;
    logic [31:0] mult_ar, mult_ac, mult_br, mult_bc;
    logic [31:0] mult_ar_s, mult_ac_s, mult_br_s, mult_bc_s;
    logic        mult_send_val;
    logic        mult_send_rdy, mult_send_rdy_s;
    logic [31:0] mult_cr, mult_cc;
    logic        send_val, send_val_s;
    logic        send_rdy;
    logic [31:0] c0r, c0c, c1r, c1c;
    logic [31:0] c0r_s, c0c_s, c1r_s, c1c_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_butterfly_stage #(.n(32), .d(16), .scale(1'b0)) u_dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy),
        .ar(ar), .ac(ac), .br(br), .bc(bc), .wr(wr), .wc(wc),
        .mult_recv_val(mult_recv_val), .mult_recv_rdy(mult_recv_rdy),
        .mult_ar(mult_ar), .mult_ac(mult_ac), .mult_br(mult_br), .mult_bc(mult_bc),
        .mult_send_val(mult_send_val), .mult_send_rdy(mult_send_rdy),
        .mult_cr(mult_cr), .mult_cc(mult_cc),
        .send_val(send_val), .send_rdy(send_rdy),
        .c0r(c0r), .c0c(c0c), .c1r(c1r), .c1c(c1c)
    );

    fft_butterfly_stage #(.n(32), .d(16), .scale(1'b1)) u_dut_s (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy_s),
        .ar(ar), .ac(ac), .br(br), .bc(bc), .wr(wr), .wc(wc),
        .mult_recv_val(mult_recv_val_s), .mult_recv_rdy(mult_recv_rdy),
        .mult_ar(mult_ar_s), .mult_ac(mult_ac_s), .mult_br(mult_br_s), .mult_bc(mult_bc_s),
        .mult_send_val(mult_send_val), .mult_send_rdy(mult_send_rdy_s),
        .mult_cr(mult_cr), .mult_cc(mult_cc),
        .send_val(send_val_s), .send_rdy(send_rdy),
        .c0r(c0r_s), .c0c(c0c_s), .c1r(c1r_s), .c1c(c1c_s)
    );

    // Behavioural Q16 complex multiplier driven by the unscaled instance.
    int          m_lat = 4;
    bit          m_stale = 1'b0;
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_pr, m_pi;

    function automatic logic [31:0] fx_re(logic signed [31:0] xr, logic signed [31:0] xi,
                                          logic signed [31:0] yr, logic signed [31:0] yi);
        longint p;
        p = (longint'(xr) * longint'(yr) - longint'(xi) * longint'(yi)) >>> 16;
        return p[31:0];
    endfunction

    function automatic logic [31:0] fx_im(logic signed [31:0] xr, logic signed [31:0] xi,
                                          logic signed [31:0] yr, logic signed [31:0] yi);
        longint p;
        p = (longint'(xr) * longint'(yi) + longint'(xi) * longint'(yr)) >>> 16;
        return p[31:0];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy        <= 1'b0;
            m_cnt         <= 0;
            m_pr          <= '0;
            m_pi          <= '0;
            mult_send_val <= 1'b0;
            mult_cr       <= '0;
            mult_cc       <= '0;
        end else begin
            if (mult_send_val && mult_send_rdy) mult_send_val <= 1'b0;
            if (!m_busy && mult_recv_val && mult_recv_rdy) begin
                m_busy <= 1'b1;
                m_cnt  <= m_lat;
                m_pr   <= fx_re(mult_ar, mult_ac, mult_br, mult_bc);
                m_pi   <= fx_im(mult_ar, mult_ac, mult_br, mult_bc);
                if (m_stale) begin
                    mult_send_val <= 1'b1;
                    mult_cr       <= 32'h1234_5678;
                    mult_cc       <= 32'h0BAD_0BAD;
                end
            end else if (m_busy) begin
                if (m_cnt > 1) begin
                    m_cnt <= m_cnt - 1;
                end else begin
                    m_busy        <= 1'b0;
                    mult_send_val <= 1'b1;
                    mult_cr       <= m_pr;
                    mult_cc       <= m_pi;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp_u / exp_s pack {c0r, c0c, c1r, c1c} for the unscaled / scaled instance.
    task automatic run_bfly(input string tag,
                            input logic [31:0] a_r, input logic [31:0] a_i,
                            input logic [31:0] b_r, input logic [31:0] b_i,
                            input logic [31:0] w_r, input logic [31:0] w_i,
                            input int lat, input int mstall, input int sstall, input bit stale,
                            input logic [127:0] exp_u, input logic [127:0] exp_s);
        int cyc;
        check({tag, ".recv_rdy_idle"}, 128'(recv_rdy), 128'(1));
        m_lat         = lat;
        m_stale       = stale;
        mult_recv_rdy = (mstall == 0);
        send_rdy      = 1'b0;
        ar = a_r; ac = a_i; br = b_r; bc = b_i; wr = w_r; wc = w_i;
        recv_val = 1'b1;
        @(posedge clk); #1;
        // Keep offering garbage operands: none may be accepted mid-flight.
        ar = 32'hA5A5_A5A5; ac = 32'h5A5A_5A5A; br = 32'hA5A5_A5A5;
        bc = 32'h5A5A_5A5A; wr = 32'hA5A5_A5A5; wc = 32'h5A5A_5A5A;
        cyc = 0;
        check({tag, ".issue_val"}, 128'({mult_recv_val, recv_rdy}), 128'(2'b10));
        check({tag, ".mult_ops"}, {mult_ar, mult_ac, mult_br, mult_bc}, {b_r, b_i, w_r, w_i});
        check({tag, ".mult_ops_s"}, {mult_ar_s, mult_ac_s, mult_br_s, mult_bc_s}, {b_r, b_i, w_r, w_i});
        repeat (mstall) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (mstall > 0) begin
            check({tag, ".issue_hold"}, {mult_ar, mult_ac, mult_br, mult_bc}, {b_r, b_i, w_r, w_i});
            check({tag, ".issue_val_hold"}, 128'({mult_recv_val, recv_rdy}), 128'(2'b10));
        end
        mult_recv_rdy = 1'b1;
        while (!send_val && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, 128'(cyc), 128'(2 + lat + mstall));
        check({tag, ".send_val_s"}, 128'({send_val_s, recv_rdy}), 128'(2'b10));
        check({tag, ".result"}, {c0r, c0c, c1r, c1c}, exp_u);
        check({tag, ".result_s"}, {c0r_s, c0c_s, c1r_s, c1c_s}, exp_s);
        repeat (sstall) begin
            @(posedge clk); #1;
        end
        if (sstall > 0) begin
            check({tag, ".send_hold"}, 128'({send_val, recv_rdy}), 128'(2'b10));
            check({tag, ".result_hold"}, {c0r, c0c, c1r, c1c}, exp_u);
        end
        send_rdy = 1'b1;
        @(posedge clk); #1;
        send_rdy = 1'b0;
        recv_val = 1'b0;
        check({tag, ".after_send"}, 128'({send_val, send_val_s, recv_rdy}), 128'(3'b001));
        $display("txn %s: latency %0d c0=(%h,%h) c1=(%h,%h) c0s=(%h,%h) c1s=(%h,%h)",
                 tag, cyc, c0r, c0c, c1r, c1c, c0r_s, c0c_s, c1r_s, c1c_s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0; mult_recv_rdy = 1'b1;
        ar = '0; ac = '0; br = '0; bc = '0; wr = '0; wc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ctrl", 128'({recv_rdy, mult_recv_val, mult_send_rdy, send_val}), 128'(4'b1000));
        check("reset.data", {c0r, c0c, c1r, c1c}, 128'(0));
        check("reset.mult_ops", {mult_ar, mult_ac, mult_br, mult_bc}, 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        run_bfly("real", 32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0, 32'h0001_0000, 32'h0,
                 4, 0, 0, 1'b0,
                 {32'h0001_8000, 32'h0, 32'h0000_8000, 32'h0},
                 {32'h0000_C000, 32'h0, 32'h0000_4000, 32'h0});

        run_bfly("jj", 32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000,
                 4, 0, 0, 1'b0,
                 {32'hFFFF_0000, 32'h0, 32'h0001_0000, 32'h0},
                 {32'hFFFF_8000, 32'h0, 32'h0000_8000, 32'h0});

        run_bfly("scale", 32'h7FFF_0000, 32'h0, 32'h0002_0000, 32'h0, 32'h0001_0000, 32'h0,
                 4, 0, 0, 1'b0,
                 {32'h8001_0000, 32'h0, 32'h7FFD_0000, 32'h0},
                 {32'h4000_8000, 32'h0, 32'h3FFE_8000, 32'h0});

        run_bfly("imag", 32'h0, 32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0001_0000, 32'h0,
                 4, 0, 0, 1'b0,
                 {32'h0000_8000, 32'h0001_4000, 32'hFFFF_8000, 32'h0000_C000},
                 {32'h0000_4000, 32'h0000_A000, 32'hFFFF_C000, 32'h0000_6000});

        run_bfly("backpressure", 32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0, 32'h0001_0000, 32'h0,
                 3, 3, 5, 1'b0,
                 {32'h0001_8000, 32'h0, 32'h0000_8000, 32'h0},
                 {32'h0000_C000, 32'h0, 32'h0000_4000, 32'h0});

        run_bfly("stale", 32'h0, 32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0001_0000, 32'h0,
                 4, 0, 0, 1'b1,
                 {32'h0000_8000, 32'h0001_4000, 32'hFFFF_8000, 32'h0000_C000},
                 {32'h0000_4000, 32'h0000_A000, 32'hFFFF_C000, 32'h0000_6000});
        m_stale = 1'b0;

        // Abandon a butterfly while it waits on the multiplier.
        m_lat = 6;
        ar = 32'h0001_0000; ac = 32'h0; br = 32'h0000_8000; bc = 32'h0; wr = 32'h0001_0000; wc = 32'h0;
        recv_val = 1'b1;
        @(posedge clk); #1;
        recv_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midreset.in_wait", 128'({mult_send_rdy, recv_rdy}), 128'(2'b10));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset.ctrl", 128'({recv_rdy, send_val, mult_recv_val, mult_send_rdy}), 128'(4'b1000));
        check("midreset.data", {c0r, c0c, c1r, c1c}, 128'(0));
        $display("txn midreset: recv_rdy %0b send_val %0b", recv_rdy, send_val);

        run_bfly("post_reset", 32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000,
                 2, 0, 0, 1'b0,
                 {32'hFFFF_0000, 32'h0, 32'h0001_0000, 32'h0},
                 {32'hFFFF_8000, 32'h0, 32'h0000_8000, 32'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
